// File: rtl/lcd_host_seq_pkg.sv
// Shared definitions for the LCD host sequencer: geometry, timing limits,
// controller command codes and the sequencer state encoding.
package lcd_host_seq_pkg;

  localparam int IMG_W   = 6;
  localparam int WIN_W   = 3;
  localparam int IMG_PIX = IMG_W * IMG_W;
  localparam int OUT_LEN = WIN_W * WIN_W;
  localparam int TIMEOUT = 255;

  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_WAIT_OUT = 3'd3,
    ST_COLLECT  = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  // Codes 6 and 7 have no controller meaning and are rejected as errors.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= CMD_DOWN);
  endfunction

endpackage

// File: rtl/lcd_host_seq_if.sv
// Bundle of everything the host sequencer exchanges with the op source,
// the image memory, the LCD controller and the result consumer.
interface lcd_host_seq_if;
  // Op handshake: a transfer happens on a rising edge where op_valid and
  // op_ready are both 1; op_valid/op_cmd stay stable until that edge, and
  // op_ready may depend combinationally on busy.
  logic       op_valid;
  logic [2:0] op_cmd;
  logic       op_ready;
  logic [5:0] pix_addr;
  logic [7:0] pix_data;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_last;
  logic       err;

  modport master (
    input  op_valid, op_cmd, pix_data, busy, dataout, output_valid,
    output op_ready, pix_addr, cmd, cmd_valid, datain,
           res_data, res_valid, res_last, err
  );

  modport slave (
    output op_valid, op_cmd, pix_data, busy, dataout, output_valid,
    input  op_ready, pix_addr, cmd, cmd_valid, datain,
           res_data, res_valid, res_last, err
  );
endinterface

// File: rtl/lcd_host_seq_watchdog.sv
// Cycle counter for the response phases; restarts on any state change or
// output_valid and flags expiry on the TIMEOUT-th idle cycle.
module lcd_host_seq_watchdog
  import lcd_host_seq_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  state_e i_state,
  input  logic   i_kick,
  input  logic   i_en,
  output logic   o_expire
);

  logic [7:0] r_cnt;
  state_e     r_prev;
  logic [7:0] w_cur;

  // w_cur is the number of quiet cycles already spent before this one.
  assign w_cur    = ((i_state != r_prev) || i_kick) ? 8'd0 : r_cnt;
  assign o_expire = i_en && (w_cur == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= 8'd0;
      r_prev <= ST_IDLE;
    end else begin
      r_prev <= i_state;
      r_cnt  <= (w_cur == 8'hFF) ? w_cur : w_cur + 8'd1;
    end
  end

endmodule

// File: rtl/lcd_host_seq.sv
// Host-side initiator for the LCD controller: issues ops, streams the 6x6
// image on LOAD, and forwards the returned window bytes to the result port.
module lcd_host_seq
  import lcd_host_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  lcd_host_seq_if.master    bus,
  output state_e            o_state
);

  state_e     r_state;
  logic [2:0] r_op;
  logic [5:0] r_cnt;
  logic [5:0] r_pix_addr;
  logic [7:0] r_datain;
  logic [2:0] r_cmd;
  logic       r_cmd_valid;
  logic [7:0] r_res_data;
  logic       r_res_valid;
  logic       r_res_last;
  logic       r_err;
  logic       r_ready_en;

  logic w_op_ready;
  logic w_accept;
  logic w_wd_en;
  logic w_expire;

  // r_ready_en keeps op_ready low while reset is held.
  assign w_op_ready = r_ready_en && (r_state == ST_IDLE) && !bus.busy && !r_err;
  assign w_accept   = bus.op_valid && w_op_ready;
  assign w_wd_en    = (r_state == ST_WAIT_OUT) || (r_state == ST_COLLECT) ||
                      (r_state == ST_DRAIN);

  lcd_host_seq_watchdog u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_state  (r_state),
    .i_kick   (bus.output_valid),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_cnt       <= 6'd0;
      r_pix_addr  <= 6'd0;
      r_datain    <= 8'd0;
      r_cmd       <= 3'd0;
      r_cmd_valid <= 1'b0;
      r_res_data  <= 8'd0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_err       <= 1'b0;
      r_ready_en  <= 1'b0;
    end else begin
      r_ready_en  <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      if (w_expire) begin
        r_err   <= 1'b1;
        r_cnt   <= 6'd0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              if (is_legal_op(bus.op_cmd)) begin
                r_op        <= bus.op_cmd;
                r_cmd       <= bus.op_cmd;
                r_cmd_valid <= 1'b1;
                r_pix_addr  <= 6'd0;
                r_state     <= ST_ISSUE;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            r_cmd <= 3'd0;
            // Address 0 was presented during this cycle, so pixel 0 is on pix_data now.
            if (r_op == CMD_LOAD) begin
              r_datain   <= bus.pix_data;
              r_pix_addr <= 6'd1;
              r_cnt      <= 6'd1;
              r_state    <= ST_LOAD;
            end else begin
              r_cnt   <= 6'd0;
              r_state <= ST_WAIT_OUT;
            end
          end
          ST_LOAD: begin
            if (bus.output_valid) begin
              r_err      <= 1'b1;
              r_datain   <= 8'd0;
              r_pix_addr <= 6'd0;
              r_cnt      <= 6'd0;
              r_state    <= ST_IDLE;
            end else if (r_cnt < 6'(IMG_PIX)) begin
              r_datain   <= bus.pix_data;
              r_cnt      <= r_cnt + 6'd1;
              r_pix_addr <= (r_cnt == 6'(IMG_PIX - 1)) ? 6'd0 : r_cnt + 6'd1;
            end else begin
              r_datain <= 8'd0;
              r_cnt    <= 6'd0;
              r_state  <= ST_WAIT_OUT;
            end
          end
          ST_WAIT_OUT, ST_COLLECT: begin
            // The first byte may land while still in WAIT_OUT; r_cnt is 0 there.
            if (bus.output_valid) begin
              r_res_data  <= bus.dataout;
              r_res_valid <= 1'b1;
              r_res_last  <= (r_cnt == 6'(OUT_LEN - 1));
              r_cnt       <= r_cnt + 6'd1;
              r_state     <= (r_cnt == 6'(OUT_LEN - 1)) ? ST_DRAIN : ST_COLLECT;
            end
          end
          ST_DRAIN: begin
            if (!bus.busy) begin
              r_cnt   <= 6'd0;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.op_ready  = w_op_ready;
  assign bus.pix_addr  = r_pix_addr;
  assign bus.cmd       = r_cmd;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.datain    = r_datain;
  assign bus.res_data  = r_res_data;
  assign bus.res_valid = r_res_valid;
  assign bus.res_last  = r_res_last;
  assign bus.err       = r_err;
  assign o_state       = r_state;

endmodule
